// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, glitch reject, framing check.
// Define UART_RX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_rx_deserializer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [7:0]      rx_data_nxt;
  logic            new_nxt, ferr_nxt;
  logic            rx_meta, rx_s;

`ifdef UART_RX_PARITY_EN
  logic            par_pend, par_pend_nxt;
  logic            perr_nxt;
  logic            par_exp;
  assign par_exp = (PARITY_ODD != 0) ? ~^shift : ^shift;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      new_rx_data <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend    <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift       <= shift_nxt;
      rx_data     <= rx_data_nxt;
      new_rx_data <= new_nxt;
      frame_err   <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_pend    <= par_pend_nxt;
      parity_err  <= perr_nxt;
`endif
    end
  end

  // START waits half a bit so every later sample lands mid-bit.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    rx_data_nxt = rx_data;
    new_nxt     = 1'b0;
    ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_pend_nxt = par_pend;
    perr_nxt     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
            par_pend_nxt = 1'b0;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shift_nxt   = {rx_s, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == BIT_LAST) begin
          cnt_nxt      = '0;
          par_pend_nxt = (rx_s != par_exp);
          state_nxt    = STOP;
        end
      end
`endif
      STOP: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_pend) begin
              perr_nxt = 1'b1;
            end else begin
              rx_data_nxt = shift;
              new_nxt     = 1'b1;
            end
`else
            rx_data_nxt = shift;
            new_nxt     = 1'b1;
`endif
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BRK;
          end
        end
      end
      BRK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
